// File: rtl/gray_wr_ptr_ctrl_pkg.sv
// Shared definitions for the gray-code FIFO pointer controllers (write side now, read side later).
package gray_wr_ptr_ctrl_pkg;

    localparam int PTR_W_MAX = 32;

    // The pointer carries one extra wrap bit beyond the RAM address.
    function automatic int ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_wr_ptr_ctrl_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/gray_wr_ptr_ctrl.sv
// Write-side pointer controller for a gray-pointer async FIFO: write pointer, read-pointer
// synchronizer and the full / almost_full / fill-count / overflow flags, all in the write domain.
module gray_wr_ptr_ctrl
    import gray_wr_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow
);

    localparam int PW = ptr_w(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

    logic [PW-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
    logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
    logic [PW-1:0] sync1_q, sync2_q;
    logic [PW-1:0] wr_count_q, wr_count_d;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;

    logic [PW-1:0] rd_bin;
    logic          accept;

    gray2bin #(
        .WIDTH (PW)
    ) u_rd_gray2bin (
        .gray_i (sync2_q),
        .bin_o  (rd_bin)
    );

    assign accept = wr_en & ~full_q;

    // Full is judged on the post-write pointer so it never lags an accepted write;
    // in gray form "one lap ahead" is the read pointer with its top two bits inverted.
    always_comb begin
        wr_ptr_bin_d  = wr_ptr_bin_q + {{(PW-1){1'b0}}, accept};
        wr_ptr_gray_d = PW'(bin2gray(PTR_W_MAX'(wr_ptr_bin_d)));
        full_d        = (wr_ptr_gray_d == {~sync2_q[PW-1:PW-2], sync2_q[PW-3:0]});
        wr_count_d    = wr_ptr_bin_d - rd_bin;
        almost_full_d = (wr_count_d >= AF_T);
        overflow_d    = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_bin_q  <= '0;
            wr_ptr_gray_q <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wr_count_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_bin_q  <= wr_ptr_bin_d;
            wr_ptr_gray_q <= wr_ptr_gray_d;
            sync1_q       <= rd_ptr_gray_async;
            sync2_q       <= sync1_q;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            wr_count_q    <= wr_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_ack      = accept;
    assign wr_addr     = wr_ptr_bin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wr_ptr_gray_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign wr_count    = wr_count_q;
    assign overflow    = overflow_q;

endmodule
